// File: rtl/console_pkg.sv
// Shared constants and state encoding for the text console writer.
// Screen geometry, blank fill code and control characters live here.
package console_pkg;

    localparam int screenW = 40;
    localparam int screenH = 30;

    localparam logic [7:0] BLANK = 8'h20;

    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] FF = 8'h0C;
    localparam logic [7:0] CR = 8'h0D;

    typedef enum logic [1:0] {
        IDLE,
        CLR_ROW,
        CLR_ALL
    } state_t;

endpackage

// File: rtl/console_cursor.sv
// Cursor position counters for the text console.
// Row change wraps from the bottom row back to the top.
module console_cursor #(
    parameter int W = console_pkg::screenW,
    parameter int H = console_pkg::screenH
) (
    input  logic       px_clk,
    input  logic       reset,
    input  logic       advance,
    input  logic       newline,
    input  logic       home,
    input  logic       cr,
    input  logic       bs,
    output logic [5:0] x,
    output logic [4:0] y,
    output logic       at_eol
);

    assign at_eol = (x == 6'(W - 1));

    // Step the cursor; home wins, and advancing past the last column starts a new row.
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (home) begin
            x <= '0;
            y <= '0;
        end else if (newline || (advance && at_eol)) begin
            x <= '0;
            y <= (y == 5'(H - 1)) ? '0 : y + 5'd1;
        end else if (advance) begin
            x <= x + 6'd1;
        end else if (cr) begin
            x <= '0;
        end else if (bs && (x != '0)) begin
            x <= x - 6'd1;
        end
    end

endmodule

// File: rtl/console_writer.sv
// Character stream to video RAM writer with row and screen clearing.
// Owns the control FSM, the clear counter and the registered VRAM port.
module console_writer #(
    parameter int         screenW = console_pkg::screenW,
    parameter int         screenH = console_pkg::screenH,
    parameter logic [7:0] BLANK   = console_pkg::BLANK
) (
    input  logic        px_clk,
    input  logic        reset,
    input  logic [7:0]  char_i,
    input  logic        char_valid_i,
    output logic        char_ready_o,
    output logic [10:0] addr_vram,
    output logic [7:0]  data_vram,
    output logic        we_vram,
    output logic [5:0]  cursor_x,
    output logic [4:0]  cursor_y
);

    import console_pkg::*;

    localparam logic [7:0]  PRINT_MIN = 8'h20;
    localparam logic [10:0] ROW_LEN   = 11'(screenW);
    localparam logic [10:0] SCR_LEN   = 11'(screenW * screenH);

    state_t      state_q, state_n;
    logic [10:0] cnt_q, cnt_n;
    logic [10:0] addr_n;
    logic [7:0]  data_n;
    logic        we_n;
    logic        ready_n;
    logic        adv, nl, home, cr, bs;
    logic        at_eol;

    function automatic logic [10:0] vaddr(input logic [4:0] y, input logic [5:0] x);
        return 11'(y) * ROW_LEN + 11'(x);
    endfunction

    console_cursor #(
        .W (screenW),
        .H (screenH)
    ) u_cursor (
        .px_clk  (px_clk),
        .reset   (reset),
        .advance (adv),
        .newline (nl),
        .home    (home),
        .cr      (cr),
        .bs      (bs),
        .x       (cursor_x),
        .y       (cursor_y),
        .at_eol  (at_eol)
    );

    // Decode accepted characters and sequence the blank-fill sweeps.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        we_n    = 1'b0;
        addr_n  = addr_vram;
        data_n  = data_vram;
        adv     = 1'b0;
        nl      = 1'b0;
        home    = 1'b0;
        cr      = 1'b0;
        bs      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (char_valid_i && char_ready_o) begin
                    unique case (1'b1)
                        (char_i >= PRINT_MIN): begin
                            we_n   = 1'b1;
                            addr_n = vaddr(cursor_y, cursor_x);
                            data_n = char_i;
                            adv    = 1'b1;
                            if (at_eol) begin
                                state_n = CLR_ROW;
                                cnt_n   = '0;
                            end
                        end
                        (char_i == LF): begin
                            nl      = 1'b1;
                            state_n = CLR_ROW;
                            cnt_n   = '0;
                        end
                        (char_i == CR): begin
                            cr = 1'b1;
                        end
                        (char_i == BS): begin
                            if (cursor_x != '0) begin
                                bs     = 1'b1;
                                we_n   = 1'b1;
                                addr_n = vaddr(cursor_y, cursor_x - 6'd1);
                                data_n = BLANK;
                            end
                        end
                        (char_i == FF): begin
                            home    = 1'b1;
                            state_n = CLR_ALL;
                            cnt_n   = '0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            CLR_ROW: begin
                if (cnt_q == ROW_LEN) begin
                    state_n = IDLE;
                end else begin
                    we_n   = 1'b1;
                    addr_n = vaddr(cursor_y, 6'd0) + cnt_q;
                    data_n = BLANK;
                    cnt_n  = cnt_q + 11'd1;
                end
            end
            CLR_ALL: begin
                if (cnt_q == SCR_LEN) begin
                    state_n = IDLE;
                end else begin
                    we_n   = 1'b1;
                    addr_n = cnt_q;
                    data_n = BLANK;
                    cnt_n  = cnt_q + 11'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        ready_n = (state_n == IDLE);
    end

    // Register state, counter and every output; reset starts a full-screen clear.
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            state_q      <= CLR_ALL;
            cnt_q        <= '0;
            we_vram      <= 1'b0;
            addr_vram    <= '0;
            data_vram    <= BLANK;
            char_ready_o <= 1'b0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            we_vram      <= we_n;
            addr_vram    <= addr_n;
            data_vram    <= data_n;
            char_ready_o <= ready_n;
        end
    end

endmodule

// File: doc/console_writer.md
CONSOLE_WRITER -- requirements
Module: console_writer

Interface
REQ-001 Parameters SHALL be:
- screenW, 40, characters per row.
- screenH, 30, rows per screen.
- BLANK, 8'h20, code written when clearing.
REQ-002 px_clk  input  1  single clock; all logic on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 char_i  input  8  character code offered by the producer.
REQ-005 char_valid_i  input  1  char_i is valid this cycle.
REQ-006 char_ready_o  output  1  writer accepts char_i this cycle.
REQ-007 addr_vram  output  11  video RAM write address, row-major: y*screenW+x.
REQ-008 data_vram  output  8  video RAM write data.
REQ-009 we_vram  output  1  video RAM write strobe, one cycle per write.
REQ-010 cursor_x  output  6  current cursor column, 0..screenW-1.
REQ-011 cursor_y  output  5  current cursor row, 0..screenH-1.

Function
REQ-012 FSM states SHALL be IDLE, CLR_ROW and CLR_ALL; char_ready_o SHALL be 1 only in IDLE.
REQ-013 A transfer SHALL occur at a rising edge where char_valid_i=1 and char_ready_o=1; char_i is consumed exactly once.
REQ-014 Printable code (>=0x20): the next cycle SHALL show we_vram=1, addr_vram=cursor_y*40+cursor_x (pre-advance), data_vram=char_i, and the cursor SHALL advance x+1 on the same edge.
REQ-015 Printables SHALL sustain one transfer per cycle while no row change results.
REQ-016 Cursor at x=39 after a printable, or LF (0x0A): x=0; y=y+1, with y=29 wrapping to 0; then enter CLR_ROW.
REQ-017 CLR_ROW SHALL issue 40 consecutive writes of BLANK to addresses newrow*40 .. newrow*40+39, ascending, then return to IDLE; ready SHALL be high in the cycle after the last clear write.
REQ-018 CR (0x0D): x=0, no VRAM write, stay in IDLE.
REQ-019 BS (0x08), x>0: x=x-1 and write BLANK at the new position next cycle; x=0: no-op, no write.
REQ-020 FF (0x0C): cursor to (0,0); CLR_ALL SHALL issue 1200 writes of BLANK to addresses 0..1199, ascending, then return to IDLE.
REQ-021 Other codes <0x20 SHALL be consumed with no write and no cursor change.
REQ-022 All outputs SHALL be registered; we_vram=0 in every cycle without a write.
REQ-023 Address arithmetic SHALL be unsigned, in at least 11 bits; addr_vram SHALL never exceed 1199.

Reset
REQ-024 On reset: state=CLR_ALL, clear counter=0, cursor=(0,0), we_vram=0, addr_vram=0, data_vram=BLANK, char_ready_o=0.
REQ-025 After reset deasserts, the first clear write (addr 0) SHALL appear in the first cycle; the full 1200-write clear SHALL run before char_ready_o rises.
REQ-026 Reset asserted mid-CLR_ROW, CLR_ALL or a stream SHALL abandon the operation immediately and restart per REQ-024.

Structure
REQ-027 Package console_pkg SHALL hold screenW, screenH, BLANK, the control codes (BS, LF, FF, CR) and the FSM state enumeration.
REQ-028 Sub-module console_cursor SHALL hold the x/y counters with advance, newline-wrap, home and backspace controls; console_writer holds the FSM, clear counter and VRAM port registers.

Verification
REQ-029 Reset release -> 1200 writes of 0x20 to addresses 0..1199 on consecutive cycles, then ready=1 with cursor (0,0).
REQ-030 Send 0x41 then 0x42 back-to-back -> writes (addr 0, 0x41) and (addr 1, 0x42) on consecutive cycles; cursor (2,0).
REQ-031 Send 40 printables from (0,0) -> writes to addr 0..39, then ready=0 and 40 clears to addr 40..79; cursor (0,1).
REQ-032 Cursor (5,29), send LF -> 40 clears to addr 0..39, cursor (0,0); CR at (7,3) -> cursor (0,3), no write.
REQ-033 BS at (0,4) -> no write; BS at (3,4) -> write 0x20 to addr 162, cursor (2,4); code 0x07 -> no effect.
REQ-034 Assert reset during the 20th CLR_ROW write -> we_vram=0 immediately, then a full 1200-write clear from addr 0.
